// File: rtl/array_arbiter_pkg.sv
// array_arbiter_pkg
//   Shared constants for the two-requester array arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths (16 x 32-bit array).
//   REQ0 / REQ1             : requester index constants.
//   CNT_W / CNT_MAX         : width and saturation value of the acceptance counter.
//   sat_inc                 : saturating increment used by the acceptance counter.
package array_arbiter_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/array_arbiter_if.sv
// array_arbiter_if
//   One array-style memory port: valid/ready handshake plus addr/we/di and the
//   asynchronous read data (dout).
//   Handshake: a transaction is transferred in the cycle where valid & ready are
//   both high. The master holds addr/we/di stable while valid & !ready; it may
//   drop valid while ready is low. Read data on dout is meaningful in the
//   transfer cycle when we is low.
//   master modport: drives valid/addr/we/di (and lock), receives ready/dout.
//   slave modport : the reverse.
//   Build option ARRAY_ARBITER_LOCK_EN adds the lock request bit.
interface array_arbiter_if
  import array_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] dout;
`ifdef ARRAY_ARBITER_LOCK_EN
  logic              lock;

  modport master (output valid, addr, we, di, lock, input ready, dout);
  modport slave  (input valid, addr, we, di, lock, output ready, dout);
`else
  modport master (output valid, addr, we, di, input ready, dout);
  modport slave  (input valid, addr, we, di, output ready, dout);
`endif

endinterface

// File: rtl/array_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational 2-way round-robin selector.
//   valid[1:0] : request vector (bit i = requester i).
//   last       : index of the requester served most recently.
//   sel        : selected requester index (0 when nothing is requested).
//   any        : at least one request is present.
module rr_pick2
  import array_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  always_comb begin
    any = |valid;
    if (valid == 2'b11) sel = ~last;   // tie goes to the one not served last
    else if (valid[1])  sel = REQ1;
    else                sel = REQ0;
  end

endmodule

// File: rtl/array_arbiter.sv
// array_arbiter
//   Round-robin arbiter sharing one array port (async read, sync write)
//   between two requesters. One transaction per cycle; read data returns in
//   the grant cycle.
//   clk, rst   : clock and asynchronous active-high reset.
//   in0, in1   : requester ports (slave side).
//   out0       : array port (master side).
//   last_grant : index of the most recently served requester (debug, reset 1).
//   busy_cnt   : saturating count of accepted transactions (debug).
//   Build option ARRAY_ARBITER_LOCK_EN: a requester that completes a
//   transaction with lock=1 owns the port until its next accepted transaction
//   with lock=0 (atomic read-modify-write).
module array_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic               clk,
  input  logic               rst,
  array_arbiter_if.slave     in0,
  array_arbiter_if.slave     in1,
  array_arbiter_if.master    out0,
  output logic               last_grant,
  output logic [CNT_W-1:0]   busy_cnt
);

  logic [1:0]        req_v;
  logic              sel;
  logic              any;
  logic              grant_v;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_di;
  logic              sel_we;

`ifdef ARRAY_ARBITER_LOCK_EN
  logic locked;
  logic owner;
  logic sel_lock;
`endif

  // While locked, the non-owner's request is hidden from the picker.
  always_comb begin
    req_v = {in1.valid, in0.valid};
`ifdef ARRAY_ARBITER_LOCK_EN
    if (locked) req_v = owner ? {in1.valid, 1'b0} : {1'b0, in0.valid};
`endif
  end

  rr_pick2 u_pick (
    .valid (req_v),
    .last  (last_grant),
    .sel   (sel),
    .any   (any)
  );

  // With nothing selected sel is 0, so the bus idles on requester 0's fields.
  assign sel_addr = sel ? in1.addr : in0.addr;
  assign sel_di   = sel ? in1.di   : in0.di;
  assign sel_we   = sel ? in1.we   : in0.we;

  // Reset gates the request so a write in flight at reset never reaches the array.
  assign grant_v = any & ~rst;
  assign accept  = grant_v & out0.ready;

  assign out0.valid = grant_v;
  assign out0.addr  = sel_addr;
  assign out0.we    = grant_v & sel_we;
  assign out0.di    = sel_di;

  assign in0.ready = accept & (sel == REQ0);
  assign in1.ready = accept & (sel == REQ1);
  assign in0.dout  = out0.dout;
  assign in1.dout  = out0.dout;

`ifdef ARRAY_ARBITER_LOCK_EN
  assign sel_lock  = sel ? in1.lock : in0.lock;
  assign out0.lock = grant_v & sel_lock;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ1;
      busy_cnt   <= '0;
`ifdef ARRAY_ARBITER_LOCK_EN
      locked     <= 1'b0;
      owner      <= 1'b0;
`endif
    end else if (accept) begin
      last_grant <= sel;
      busy_cnt   <= sat_inc(busy_cnt);
`ifdef ARRAY_ARBITER_LOCK_EN
      // When locked only the owner can be accepted, so sel == owner here.
      if (!locked) begin
        if (sel_lock) begin
          locked <= 1'b1;
          owner  <= sel;
        end
      end else if (!sel_lock) begin
        locked <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/array_arbiter.md
Name: array_arbiter

Overview:
- Two-requester, round-robin arbiter that shares the single `Array` memory port (async read, sync write) between two client ports.
- Sits between producers/consumers in a compiled-module testbench and the array model.
- Each client sees a port identical to the array's own port: valid/ready/addr/we/di/do.
- One transaction per cycle; read data returns in the grant cycle.

Parameters:
- ADDR_W, 4, address width; matches array depth 16.
- DATA_W, 32, data word width; matches array int width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 request.
- in0_ready  output  1  requester 0 granted and accepted this cycle.
- in0_addr  input  ADDR_W  requester 0 address.
- in0_we  input  1  requester 0 write enable.
- in0_di  input  DATA_W  requester 0 write data.
- in0_do  output  DATA_W  requester 0 read data.
- in1_valid, in1_ready, in1_addr, in1_we, in1_di, in1_do: same as in0_*, for requester 1.
- out0_valid  output  1  request to array.
- out0_ready  input  1  array accepts.
- out0_addr  output  ADDR_W  array address.
- out0_we  output  1  array write enable.
- out0_di  output  DATA_W  array write data.
- out0_do  input  DATA_W  array read data.
- last_grant  output  1  index of the most recently served requester (debug).

Behaviour:
- Reset: the reset value of `last_grant` is 1, so requester 0 wins the first tie. Derived outputs are 0 while rst is high: in0_ready, in1_ready, out0_valid, out0_we.
- State: `last_grant` (1 bit), `busy_cnt` (16-bit count of accepted transactions; reset 0; saturates at 0xFFFF).
- Grant (combinational, same cycle):
  - If only one valid is high, that requester is selected.
  - If both are high, the requester != last_grant is selected.
  - If neither is high, nothing is selected; out0_valid = 0 and out0_addr/we/di are driven from requester 0, with we forced to 0.
- Mux: out0_valid = valid of the selected requester; out0_addr, out0_we and out0_di come from the selected requester.
- Ready: inX_ready = selected(X) & out0_ready; the unselected requester's ready is 0.
- Read data: in0_do = in1_do = out0_do, always driven. Data is meaningful only when that requester's ready is high and its we is low (zero-latency read).
- Acceptance: a transaction is accepted when out0_valid & out0_ready.
  - On the next posedge, last_grant <= selected index and busy_cnt increments.
  - With no acceptance, last_grant holds.
- Fairness: with both valid held continuously, grants alternate every cycle: 0, 1, 0, 1, …
- Array stall: if out0_ready = 0, nothing is accepted, last_grant holds, and the same requester stays selected next cycle.
- Requester dropout: a requester may drop valid while not ready; the grant then re-evaluates combinationally.
- Reset mid-operation: an asynchronous rst immediately forces the reset values. The array's write of that edge still occurs only if out0_valid was high at the edge, so asserting rst before the edge suppresses the write.
- Requesters must hold addr/we/di stable while valid & !ready.

Optional Feature:
- Macro: ARRAY_ARBITER_LOCK_EN.
- When defined, the block adds inputs in0_lock and in1_lock (1 bit each) and a `locked` state bit plus an owner bit, both reset to 0.
  - Lock is taken when a transaction by X is accepted with inX_lock = 1.
  - While locked, only the owner can be selected, even if the other requester is valid.
  - The lock is released on the owner's first accepted transaction with lock = 0, enabling atomic read-modify-write.
  - last_grant still updates on every acceptance.
- When undefined, there are no lock ports and pure round-robin applies.

Decomposition:
- Shared package/header: ADDR_W and DATA_W defaults, requester index constants REQ0 = 0 and REQ1 = 1.
- Natural sub-module: rr_pick2. It is a combinational 2-way round-robin selector with inputs valid[1:0] and last, and outputs sel and any.
- The arbiter instantiates rr_pick2 and keeps all state.

Test Plan:
- Reset, then in0 reads addr 5 alone → in0_ready = 1 in the same cycle, in0_do = 5; last_grant = 0 next cycle.
- Both valid, in0 writes 0xAA to addr 3 and in1 reads addr 3 each cycle → grants alternate 0, 1, 0, 1; in1's first read returns 0xAA.
- out0_ready forced 0 for 3 cycles with both valid → neither ready, last_grant unchanged, busy_cnt unchanged; the expected requester wins the cycle ready returns.
- rst pulsed mid-write (in1 writes 0x55 to addr 7, rst rises before the edge) → outputs zero immediately, addr 7 keeps 7, last_grant = 1 after reset.
- LOCK_EN: in0 reads addr 2 with lock = 1, then writes 9 with lock = 0 while in1 is valid throughout → in1 is blocked for both cycles and granted on the third; addr 2 = 9.
- 70000 back-to-back accepted transactions → busy_cnt saturates at 0xFFFF.
